// File: rtl/mips_mem_pkg.sv
// Shared definitions for the load/store unit: op-field layout, access-size
// encodings, FSM state type and the misalignment/illegal-size test.
package mips_mem_pkg;

   localparam int OP_STORE = 3;
   localparam int OP_UNS   = 2;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   localparam logic [1:0] SZ_ILL  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RD,
      ST_WR,
      ST_RESP
   } lsu_state_e;

   function automatic logic isFault(input logic [1:0] size, input logic [1:0] offset);
      return (size == SZ_ILL) ||
             ((size == SZ_HALF) && offset[0]) ||
             ((size == SZ_WORD) && (offset != 2'd0));
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian lane steering: extracts a sign/zero-extended byte or halfword
// from a memory word, and merges store data into the addressed lane(s).
module lsu_lane_align
   import mips_mem_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  offset_i,
   input  logic [1:0]  size_i,
   input  logic        uns_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] merged_o
);

   logic [4:0]  shift;
   logic [7:0]  byteSel;
   logic [15:0] halfSel;

   // Byte offset 0 lives in the most significant lane, hence the inverted offset.
   assign shift   = {~offset_i, 3'b000};
   assign byteSel = 8'(word_i >> shift);
   assign halfSel = offset_i[1] ? word_i[15:0] : word_i[31:16];

   always_comb begin
      load_o   = word_i;
      merged_o = wdata_i;
      case (size_i)
         SZ_BYTE: begin
            load_o   = {{24{~uns_i & byteSel[7]}}, byteSel};
            merged_o = (word_i & ~(32'h0000_00FF << shift)) |
                       ({24'd0, wdata_i[7:0]} << shift);
         end
         SZ_HALF: begin
            load_o   = {{16{~uns_i & halfSel[15]}}, halfSel};
            merged_o = offset_i[1] ? {word_i[31:16], wdata_i[15:0]}
                                   : {wdata_i[15:0], word_i[15:0]};
         end
         default: begin
            load_o   = word_i;
            merged_o = wdata_i;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one CPU load/store into word-aligned req/ack memory
// transactions, with read-modify-write for sub-word stores.
module load_store_unit
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_fault,
   output logic              mem_req,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack
);

   lsu_state_e        state_q, state_d;
   logic              store_q, store_d;
   logic              uns_q, uns_d;
   logic [1:0]        size_q, size_d;
   logic [1:0]        off_q, off_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              fault_q, fault_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              memReq_q, memReq_d;
   logic              memWrite_q, memWrite_d;
   logic [ADDR_W-1:0] memAddr_q, memAddr_d;
   logic [31:0]       memWdata_q, memWdata_d;
   logic [31:0]       loadData;
   logic [31:0]       mergedWord;

   lsu_lane_align u_align (
      .word_i   (mem_rdata),
      .offset_i (off_q),
      .size_i   (size_q),
      .uns_i    (uns_q),
      .wdata_i  (wdata_q),
      .load_o   (loadData),
      .merged_o (mergedWord)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         store_q    <= 1'b0;
         uns_q      <= 1'b0;
         size_q     <= SZ_BYTE;
         off_q      <= 2'd0;
         wdata_q    <= '0;
         fault_q    <= 1'b0;
         rdata_q    <= '0;
         memReq_q   <= 1'b0;
         memWrite_q <= 1'b0;
         memAddr_q  <= '0;
         memWdata_q <= '0;
      end else begin
         state_q    <= state_d;
         store_q    <= store_d;
         uns_q      <= uns_d;
         size_q     <= size_d;
         off_q      <= off_d;
         wdata_q    <= wdata_d;
         fault_q    <= fault_d;
         rdata_q    <= rdata_d;
         memReq_q   <= memReq_d;
         memWrite_q <= memWrite_d;
         memAddr_q  <= memAddr_d;
         memWdata_q <= memWdata_d;
      end
   end

   // Bus controls are computed one cycle ahead so every memory output is a flop.
   always_comb begin
      state_d    = state_q;
      store_d    = store_q;
      uns_d      = uns_q;
      size_d     = size_q;
      off_d      = off_q;
      wdata_d    = wdata_q;
      fault_d    = fault_q;
      rdata_d    = rdata_q;
      memReq_d   = memReq_q;
      memWrite_d = memWrite_q;
      memAddr_d  = memAddr_q;
      memWdata_d = memWdata_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               store_d = req_op[OP_STORE];
               uns_d   = req_op[OP_UNS];
               size_d  = req_op[1:0];
               off_d   = req_addr[1:0];
               wdata_d = req_wdata;
               fault_d = isFault(req_op[1:0], req_addr[1:0]);
               rdata_d = '0;
               if (isFault(req_op[1:0], req_addr[1:0])) begin
                  state_d = ST_RESP;
               end else begin
                  memReq_d  = 1'b1;
                  memAddr_d = {req_addr[ADDR_W-1:2], 2'b00};
                  if (req_op[OP_STORE] && (req_op[1:0] == SZ_WORD)) begin
                     memWrite_d = 1'b1;
                     memWdata_d = req_wdata;
                     state_d    = ST_WR;
                  end else begin
                     memWrite_d = 1'b0;
                     state_d    = ST_RD;
                  end
               end
            end
         end
         ST_RD: begin
            if (mem_ack) begin
               if (store_q) begin
                  memWrite_d = 1'b1;
                  memWdata_d = mergedWord;
                  state_d    = ST_WR;
               end else begin
                  rdata_d  = loadData;
                  memReq_d = 1'b0;
                  state_d  = ST_RESP;
               end
            end
         end
         ST_WR: begin
            if (mem_ack) begin
               memReq_d   = 1'b0;
               memWrite_d = 1'b0;
               state_d    = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_rdata = (state_q == ST_RESP) ? rdata_q : 32'd0;
   assign rsp_fault = (state_q == ST_RESP) && fault_q;
   assign mem_req   = memReq_q;
   assign mem_write = memWrite_q;
   assign mem_addr  = memAddr_q;
   assign mem_wdata = memWdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random loads and
// stores against a byte-array reference model and a req/ack memory responder.
module tb_load_store_unit;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;
   logic        mem_req;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   int errors = 0;
   int checks = 0;
   logic [31:0] tbMem [logic [31:0]];

   load_store_unit #(.ADDR_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_fault (rsp_fault),
      .mem_req   (mem_req),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Memory viewed as four bytes, byte 0 being the most significant.
   function automatic logic [31:0] refLoad(input logic [31:0] w, input int off, input int size, input bit uns);
      int     b [4];
      longint v;
      int     width;
      for (int k = 0; k < 4; k++) b[k] = int'((w >> (8 * (3 - k))) & 32'hFF);
      if (size == 2) return w;
      if (size == 0) begin
         v = b[off];
         width = 8;
      end else begin
         v = b[off] * 256 + b[off + 1];
         width = 16;
      end
      if (!uns && v >= (longint'(1) << (width - 1))) v = v - (longint'(1) << width);
      return 32'(v);
   endfunction

   function automatic logic [31:0] refStore(input logic [31:0] w, input int off, input int size, input logic [31:0] wd);
      int b [4];
      if (size == 2) return wd;
      for (int k = 0; k < 4; k++) b[k] = int'((w >> (8 * (3 - k))) & 32'hFF);
      if (size == 0) begin
         b[off] = int'(wd & 32'hFF);
      end else begin
         b[off]     = int'((wd >> 8) & 32'hFF);
         b[off + 1] = int'(wd & 32'hFF);
      end
      return 32'((b[0] << 24) | (b[1] << 16) | (b[2] << 8) | b[3]);
   endfunction

   // One complete request: handshake, serve memory with the given wait
   // states per transaction, then check response, latency and memory effect.
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                                input int waits, output logic [31:0] gotData);
      bit          store, uns, fault, done, readyBad, addrBad, gotFault;
      int          size, off, txns, expLat, cycle, pend, reads, writes, reqCycles;
      logic [31:0] wa, pre, expData, expWord;
      store = op[3];
      uns   = op[2];
      size  = int'(op[1:0]);
      off   = int'(addr[1:0]);
      wa    = addr & 32'hFFFF_FFFC;
      fault = (size == 3) || (size == 1 && off % 2 == 1) || (size == 2 && off != 0);
      pre   = tbMem.exists(wa) ? tbMem[wa] : 32'd0;
      tbMem[wa] = pre;
      expData = (fault || store) ? 32'd0 : refLoad(pre, off, size, uns);
      expWord = (store && !fault) ? refStore(pre, off, size, wd) : pre;
      txns    = fault ? 0 : ((store && size != 2) ? 2 : 1);
      expLat  = fault ? 1 : 1 + txns * (waits + 1);
      gotData = 32'hX;
      gotFault = 1'b0;
      done = 0; readyBad = 0; addrBad = 0;
      cycle = 0; reads = 0; writes = 0; reqCycles = 0;
      pend = waits;

      @(negedge clk);
      checkOutput("req_ready_idle", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wd;
      @(posedge clk);
      while (!done && cycle < 60) begin
         @(negedge clk);
         cycle++;
         req_valid = 1'b0;
         req_op    = 4'($urandom);
         req_addr  = $urandom;
         mem_ack   = 1'b0;
         mem_rdata = $urandom;
         if (req_ready !== 1'b0) readyBad = 1;
         if (rsp_valid === 1'b1) begin
            done     = 1;
            gotData  = rsp_rdata;
            gotFault = rsp_fault;
         end else if (mem_req === 1'b1) begin
            reqCycles++;
            if (mem_addr !== wa) addrBad = 1;
            if (pend > 0) begin
               pend--;
            end else begin
               mem_ack = 1'b1;
               pend    = waits;
               if (mem_write) begin
                  tbMem[wa] = mem_wdata;
                  writes++;
               end else begin
                  mem_rdata = tbMem[wa];
                  reads++;
               end
            end
         end
      end
      mem_ack = 1'b0;

      checkOutput("rsp_seen", {31'd0, done}, 32'd1);
      checkOutput("latency", cycle, expLat);
      checkOutput("rsp_rdata", gotData, expData);
      checkOutput("rsp_fault", {31'd0, gotFault}, {31'd0, fault});
      checkOutput("mem_reads", reads, (fault || (store && size == 2)) ? 0 : 1);
      checkOutput("mem_writes", writes, (store && !fault) ? 1 : 0);
      checkOutput("mem_req_cycles", reqCycles, txns * (waits + 1));
      checkOutput("busy_not_ready", {31'd0, readyBad}, 32'd0);
      checkOutput("mem_addr", {31'd0, addrBad}, 32'd0);
      checkOutput("mem_word", tbMem[wa], expWord);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
      checkOutput({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
      checkOutput({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
      checkOutput({tag, "_rsp_fault"}, {31'd0, rsp_fault}, 32'd0);
      checkOutput({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
      checkOutput({tag, "_mem_write"}, {31'd0, mem_write}, 32'd0);
      checkOutput({tag, "_mem_addr"}, mem_addr, 32'd0);
      checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'd0);
   endtask

   initial begin
      logic [31:0] d;
      int          rspSeen;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_op    = 4'd0;
      req_addr  = 32'd0;
      req_wdata = 32'd0;
      mem_rdata = 32'd0;
      mem_ack   = 1'b0;
      repeat (2) @(negedge clk);
      checkResetOutputs("reset");
      rst_n = 1'b1;

      tbMem[32'h100] = 32'h8899AABB;
      applyStimulus(4'b0000, 32'h101, 32'd0, 0, d);
      checkOutput("lb_0x101", d, 32'hFFFFFF99);
      applyStimulus(4'b0100, 32'h101, 32'd0, 0, d);
      checkOutput("lbu_0x101", d, 32'h00000099);
      applyStimulus(4'b0001, 32'h102, 32'd0, 0, d);
      checkOutput("lh_0x102", d, 32'hFFFFAABB);
      applyStimulus(4'b0010, 32'h100, 32'd0, 0, d);
      checkOutput("lw_0x100", d, 32'h8899AABB);
      applyStimulus(4'b1000, 32'h103, 32'h12, 0, d);
      checkOutput("sb_merge", tbMem[32'h100], 32'h8899AA12);
      applyStimulus(4'b1010, 32'h200, 32'hDEADBEEF, 0, d);
      checkOutput("sw_word", tbMem[32'h200], 32'hDEADBEEF);
      applyStimulus(4'b0010, 32'h102, 32'd0, 0, d);
      applyStimulus(4'b0001, 32'h101, 32'd0, 0, d);
      applyStimulus(4'b0011, 32'h100, 32'd0, 0, d);
      applyStimulus(4'b0010, 32'h100, 32'd0, 3, d);
      checkOutput("lw_wait", d, 32'h8899AA12);

      // Reset in the write phase of a halfword read-modify-write.
      tbMem[32'h400] = 32'h11223344;
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = 4'b1001;
      req_addr  = 32'h402;
      req_wdata = 32'h0000BEEF;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      checkOutput("sh_rd_req", {30'd0, mem_req, mem_write}, 32'd2);
      mem_ack   = 1'b1;
      mem_rdata = tbMem[32'h400];
      @(negedge clk);
      mem_ack = 1'b0;
      checkOutput("sh_wr_req", {30'd0, mem_req, mem_write}, 32'd3);
      checkOutput("sh_wr_data", mem_wdata, 32'h1122BEEF);
      rst_n = 1'b0;
      #1;
      checkResetOutputs("midreset");
      rspSeen = 0;
      repeat (3) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0) rspSeen++;
      end
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0) rspSeen++;
      end
      checkOutput("no_rsp_after_reset", rspSeen, 0);
      applyStimulus(4'b0010, 32'h400, 32'd0, 0, d);
      checkOutput("lw_after_reset", d, 32'h11223344);

      for (int a = 32'h300; a < 32'h320; a += 4) tbMem[a] = $urandom;
      for (int n = 0; n < 40; n++) begin
         logic [3:0]  op;
         logic [31:0] addr;
         op   = 4'($urandom);
         addr = 32'h300 + 32'($urandom_range(0, 31));
         applyStimulus(op, addr, $urandom, int'($urandom_range(0, 2)), d);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
